tagged_mul_arbiter: RTL and testbench
=====================================

# tagged_mul_arbiter

Round-robin scheduler that shares one `tagged_mul` squaring unit between `NUM_REQ` ray-direction requesters in the normalization path. It grants one `TaggedDirection` per cycle to the multiplier and tracks the requester ID of each in-flight operation. It captures each `TaggedDirection_pow` result into a credit-protected return FIFO and routes it back to the originating requester. The multiplier cannot stall, so issue is throttled by credits and no result is ever dropped.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, `` `WIDTH ``: fixed-point word width, forwarded to the multiplier.
- `Q_BITS`, `` `Q_BITS ``: fractional bits, forwarded to the multiplier.
- `MUL_LATENCY`, 1: cycles from `mul_start` to valid `mul_tdp`, at least 1.
- `FIFO_DEPTH`, 4: return FIFO entries, power of 2, at least 2.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_dir`  in  NUM_REQ x TaggedDirection  per-requester direction plus tag.
- `req_ready`  out  NUM_REQ  one-hot grant; a transfer occurs when valid and ready are both high.
- `mul_start`  out  1  issue strobe to the multiplier.
- `mul_dir`  out  TaggedDirection  operand to the multiplier.
- `mul_tdp`  in  TaggedDirection_pow  multiplier result.
- `resp_valid`  out  NUM_REQ  one-hot: the FIFO head belongs to this requester.
- `resp_data`  out  TaggedDirection_pow  FIFO head, broadcast to all requesters.
- `resp_ready`  in  NUM_REQ  per-requester pop acknowledge.

## Operation
- **Arbitration**
  - Round-robin pointer `rr_ptr`, reset to 0.
  - Grant goes to the first requester with `req_valid` set, searching from `rr_ptr` upward and wrapping.
  - `req_ready` is combinational: the one-hot grant gated by `credit_ok`.
  - After a transfer, `rr_ptr` becomes the granted index + 1, modulo `NUM_REQ`.
  - With no transfer, `rr_ptr` holds.
- **Issue**
  - `mul_start` and `mul_dir` are registered.
  - A transfer in cycle T drives `mul_start`=1 and `mul_dir`=the granted `req_dir` in cycle T+1. Otherwise `mul_start`=0 and `mul_dir` holds.
- **ID pipeline**
  - A shift register of depth `MUL_LATENCY` holds {valid, id} and is advanced each cycle, with the issue entry inserted.
  - When the entry emerges, `mul_tdp` is pushed into the FIFO together with the id.
  - The result arrives `MUL_LATENCY` cycles after `mul_start`.
- **Credits**
  - `inflight` counts valid entries in the issue register plus the ID pipeline.
  - `credit_ok` = (`fifo_count` + `inflight` < `FIFO_DEPTH`).
  - A pop in the same cycle is not credited until the next cycle. This is conservative by design.
- **Return FIFO**
  - Registered head with no bypass.
  - `resp_valid[head_id]`=1 when not empty. `resp_data` is the head entry.
  - Pop occurs on `resp_ready[head_id]`. `resp_ready` of any non-head requester is ignored.
  - Push and pop in the same cycle are both performed and the count is unchanged.
  - Overflow is impossible by construction; the bench asserts it never occurs.
- **No arithmetic**
  - Results pass unmodified. Tags are never inspected.

## Timing
- **Reset values**
  - `mul_start`=0, `mul_dir`=0, `resp_valid`=0, `resp_data`=0.
  - `rr_ptr`=0, FIFO empty, ID pipeline cleared.
  - `req_ready`=0 while `rst` is high.
- **Latency**
  - Accept at cycle T → `mul_start` at T+1 → FIFO push at the edge ending T+1+`MUL_LATENCY` → `resp_valid` at T+2+`MUL_LATENCY`.
  - With defaults, T+3.
- **Throughput**
  - 1 issue per cycle while credits are available.
  - Sustained full rate requires `FIFO_DEPTH` ≥ `MUL_LATENCY`+3. The default (4 = 1+3) meets this.
- **Reset mid-operation**
  - In-flight and queued results are discarded.
  - Multiplier outputs that arrive after reset are ignored, because the ID pipeline is cleared.

## Configuration
- `` `TMUL_ARB_STATS_EN ``, when defined:
  - Adds output `stat_issued` [31:0], counting transfers.
  - Adds output `stat_stall` [31:0], counting cycles with any `req_valid` high and `credit_ok`=0.
  - Both counters are 0 at reset and saturate at all-ones.
- When undefined, these ports and counters do not exist, and behaviour is otherwise identical.

## Test plan
- **Single request:** req 2 sends x=2.0, y=-1.5, z=0.5, tag=0x1234 at T → `resp_valid`=4'b0100 at T+3 with pow x=4.0, y=2.25, z=0.25, tag 0x1234.
- **All four held valid from reset:** grants in order 0,1,2,3,0, one per cycle. Responses return in the same order with matching tags.
- **Backpressure:** all `resp_ready`=0 with continuous requests → exactly 4 transfers, then `req_ready`=0. Releasing `resp_ready` restores issue one cycle after the first pop.
- **Simultaneous push/pop:** head popped in the same cycle a result lands → `fifo_count` is unchanged and the next head is correct.
- **Reset mid-operation:** assert `rst` with 2 results queued and 1 in flight → all outputs return to 0, and no `resp_valid` appears afterwards.
- **Stats (`TMUL_ARB_STATS_EN`):** backpressure scenario → `stat_issued`=4, and `stat_stall` increments once per blocked cycle.

Source files
------------

// File: rtl/tagged_mul_arbiter.sv
// tagged_mul_arbiter
//   Round-robin scheduler sharing one tagged_mul squaring unit between
//   NUM_REQ requesters. One TaggedDirection is issued per cycle. The
//   requester id of every in-flight operation is tracked in a shift
//   register that matches the multiplier latency. Each result lands in a
//   credit-protected return FIFO and is steered back to its requester.
//
//   TaggedDirection / TaggedDirection_pow are packed as
//   {tag[15:0], z, y, x}, with each component WIDTH bits wide.
//
// Ports
//   clk, rst                clock, asynchronous active-high reset
//   req_valid/req_dir       per-requester request (req_dir flattened)
//   req_ready               one-hot grant (gated by credits)
//   mul_start/mul_dir       registered issue to the multiplier
//   mul_tdp                 multiplier result, MUL_LATENCY after mul_start
//   resp_valid/resp_data    one-hot owner of FIFO head, head data
//   resp_ready              per-requester pop acknowledge
//
// Optional feature macro: TMUL_ARB_STATS_EN adds the saturating
//   counters stat_issued (transfers) and stat_stall (cycles with a
//   pending request blocked by credits).

`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef Q_BITS
`define Q_BITS 8
`endif

module tagged_mul_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = `WIDTH,
    parameter int Q_BITS      = `Q_BITS,
    parameter int MUL_LATENCY = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*(3*WIDTH+16)-1:0] req_dir,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           mul_start,
    output logic [3*WIDTH+16-1:0]          mul_dir,
    input  logic [3*WIDTH+16-1:0]          mul_tdp,
    output logic [NUM_REQ-1:0]             resp_valid,
    output logic [3*WIDTH+16-1:0]          resp_data,
    input  logic [NUM_REQ-1:0]             resp_ready
`ifdef TMUL_ARB_STATS_EN
    ,
    output logic [31:0]                    stat_issued,
    output logic [31:0]                    stat_stall
`endif
);

    localparam int DIR_W = 3 * WIDTH + 16;
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + MUL_LATENCY + 2) + 1;

    // Elaboration-time parameter sanity checks
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("tagged_mul_arbiter: NUM_REQ must be 2..8");
    end
    if (MUL_LATENCY < 1) begin : g_bad_latency
        $error("tagged_mul_arbiter: MUL_LATENCY must be at least 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("tagged_mul_arbiter: FIFO_DEPTH must be a power of 2, at least 2");
    end
    if (Q_BITS >= WIDTH) begin : g_bad_q
        $error("tagged_mul_arbiter: Q_BITS must be smaller than WIDTH");
    end

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_found;
    logic               credit_ok;
    logic               transfer;
    int                 cand;

    logic [ID_W-1:0]    issue_id;
    logic [MUL_LATENCY-1:0] pipe_valid;
    logic [ID_W-1:0]    pipe_id [MUL_LATENCY];
    logic [CNT_W-1:0]   inflight;

    logic [DIR_W-1:0]   fifo_data [FIFO_DEPTH];
    logic [ID_W-1:0]    fifo_id   [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W:0]     fifo_count;
    logic               fifo_empty;
    logic [ID_W-1:0]    head_id;
    logic               push_en;
    logic               pop_en;

    // Round-robin search: walk offsets from the highest down so the
    // smallest offset from rr_ptr is the last (winning) assignment.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = rr_ptr;
        cand        = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (req_valid[ID_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    // Credits cover the issue register plus every pipeline slot, because
    // the multiplier cannot be stalled once an operand is issued.
    always_comb begin
        inflight = CNT_W'(mul_start);
        for (int k = 0; k < MUL_LATENCY; k++) begin
            inflight = inflight + CNT_W'(pipe_valid[k]);
        end
    end

    assign credit_ok = (CNT_W'(fifo_count) + inflight) < CNT_W'(FIFO_DEPTH);
    assign transfer  = grant_found & credit_ok & ~rst;
    assign req_ready = transfer ? (NUM_REQ'(1) << grant_idx) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            mul_start <= 1'b0;
            mul_dir   <= '0;
            issue_id  <= '0;
        end else begin
            mul_start <= transfer;
            if (transfer) begin
                mul_dir  <= req_dir[int'(grant_idx) * DIR_W +: DIR_W];
                issue_id <= grant_idx;
                rr_ptr   <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // Id pipeline mirrors the multiplier latency; its output marks the
    // cycle in which mul_tdp is valid and whose requester owns it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            for (int k = 0; k < MUL_LATENCY; k++) begin
                pipe_id[k] <= '0;
            end
        end else begin
            pipe_valid[0] <= mul_start;
            pipe_id[0]    <= issue_id;
            for (int k = 1; k < MUL_LATENCY; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                pipe_id[k]    <= pipe_id[k-1];
            end
        end
    end

    assign push_en    = pipe_valid[MUL_LATENCY-1];
    assign fifo_empty = (fifo_count == '0);
    assign head_id    = fifo_id[rd_ptr];
    assign pop_en     = ~fifo_empty & resp_ready[head_id];
    assign resp_valid = fifo_empty ? '0 : (NUM_REQ'(1) << head_id);
    assign resp_data  = fifo_empty ? '0 : fifo_data[rd_ptr];

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_en) begin
            fifo_data[wr_ptr] <= mul_tdp;
            fifo_id[wr_ptr]   <= pipe_id[MUL_LATENCY-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef TMUL_ARB_STATS_EN
    logic stall;
    assign stall = (|req_valid) & ~credit_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (transfer && stat_issued != '1) begin
                stat_issued <= stat_issued + 1'b1;
            end
            if (stall && stat_stall != '1) begin
                stat_stall <= stat_stall + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tagged_mul_arbiter.sv
// tb_tagged_mul_arbiter
//   Directed bench for tagged_mul_arbiter with the default parameters.
//   A behavioural squaring unit with latency 1 sits on the mul_* ports.
//   Expected values are hand-computed constants (Q8.8 words).
//   With TMUL_ARB_STATS_EN defined, the statistics counters are also checked.

`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef Q_BITS
`define Q_BITS 8
`endif

module tb_tagged_mul_arbiter;

    localparam int NUM_REQ = 4;
    localparam int W       = `WIDTH;
    localparam int Q       = `Q_BITS;
    localparam int DIR_W   = 3 * W + 16;
    localparam int DEPTH   = 4;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [NUM_REQ-1:0]         req_valid = '0;
    logic [NUM_REQ*DIR_W-1:0]   req_dir = '0;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       mul_start;
    logic [DIR_W-1:0]           mul_dir;
    logic [DIR_W-1:0]           mul_tdp = '0;
    logic [NUM_REQ-1:0]         resp_valid;
    logic [DIR_W-1:0]           resp_data;
    logic [NUM_REQ-1:0]         resp_ready = '0;
`ifdef TMUL_ARB_STATS_EN
    logic [31:0]                stat_issued;
    logic [31:0]                stat_stall;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int overflowEvents = 0;

    tagged_mul_arbiter #(
        .NUM_REQ(NUM_REQ), .WIDTH(W), .Q_BITS(Q), .MUL_LATENCY(1), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_dir(req_dir), .req_ready(req_ready),
        .mul_start(mul_start), .mul_dir(mul_dir), .mul_tdp(mul_tdp),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready)
`ifdef TMUL_ARB_STATS_EN
        , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural squaring unit: each component squared in Q format, tag kept
    function automatic logic [DIR_W-1:0] squareDir(input logic [DIR_W-1:0] d);
        logic signed [2*W-1:0] p;
        logic [3*W-1:0] r;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            p = $signed(d[c*W +: W]) * $signed(d[c*W +: W]);
            p = p >>> Q;
            r[c*W +: W] = p[W-1:0];
        end
        return {d[DIR_W-1 -: 16], r};
    endfunction

    always @(posedge clk) begin
        if (mul_start) begin
            mul_tdp <= squareDir(mul_dir);
        end
    end

    // Overflow watch: a push into a full FIFO without a same-cycle pop
    always @(negedge clk) begin
        if (!rst && dut.push_en && !dut.pop_en && dut.fifo_count == (DEPTH)) begin
            overflowEvents++;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DIR_W-1:0] mkDir(input logic [15:0] tag, input logic [W-1:0] z,
                                               input logic [W-1:0] y, input logic [W-1:0] x);
        return {tag, z, y, x};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic [NUM_REQ-1:0] ready);
        req_valid  = valid;
        resp_ready = ready;
    endtask

    task automatic setDir(input int idx, input logic [DIR_W-1:0] d);
        req_dir[idx*DIR_W +: DIR_W] = d;
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit into cycle 0 with reset released
    task automatic applyReset;
        applyStimulus('0, '0);
        rst = 1'b1;
        repeat (2) nextCycle;
        rst = 1'b0;
    endtask

    initial begin
        int xfers;
        int spurious;
        $display("[TB] tagged_mul_arbiter directed test");

        // Reset values, with every requester asserting valid
        applyStimulus(4'b1111, 4'b1111);
        repeat (2) nextCycle;
        #1;
        checkOutput("rst_req_ready",  64'(req_ready),  64'h0);
        checkOutput("rst_mul_start",  64'(mul_start),  64'h0);
        checkOutput("rst_mul_dir",    64'(mul_dir),    64'h0);
        checkOutput("rst_resp_valid", 64'(resp_valid), 64'h0);
        checkOutput("rst_resp_data",  64'(resp_data),  64'h0);

        // Single request from requester 2: x=2.0 y=-1.5 z=0.5 tag 1234
        applyReset();
        setDir(2, mkDir(16'h1234, 16'h0080, 16'hFE80, 16'h0200));
        applyStimulus(4'b0100, 4'b0000);
        #1;
        checkOutput("single_grant", 64'(req_ready), 64'h4);
        nextCycle;
        applyStimulus(4'b0000, 4'b0000);
        #1;
        checkOutput("single_mul_start", 64'(mul_start), 64'h1);
        checkOutput("single_mul_dir", mul_dir, 64'h1234_0080_FE80_0200);
        nextCycle;
        #1;
        checkOutput("single_not_yet", 64'(resp_valid), 64'h0);
        nextCycle;
        #1;
        checkOutput("single_resp_valid", 64'(resp_valid), 64'h4);
        checkOutput("single_resp_data", resp_data, 64'h1234_0040_0240_0400);
        applyStimulus(4'b0000, 4'b1011);
        nextCycle;
        #1;
        checkOutput("non_head_ready_ignored", 64'(resp_valid), 64'h4);
        applyStimulus(4'b0000, 4'b0100);
        nextCycle;
        #1;
        checkOutput("single_popped", 64'(resp_valid), 64'h0);

        // All four held valid: grants 0,1,2,3,0 and responses in order
        applyReset();
        setDir(0, mkDir(16'h00A0, 16'h0000, 16'h0000, 16'h0100));
        setDir(1, mkDir(16'h00A1, 16'h0000, 16'h0000, 16'h0200));
        setDir(2, mkDir(16'h00A2, 16'h0000, 16'h0000, 16'h0300));
        setDir(3, mkDir(16'h00A3, 16'h0000, 16'h0000, 16'h0080));
        begin
            logic [63:0] expPow [4];
            expPow[0] = 64'h00A0_0000_0000_0100;
            expPow[1] = 64'h00A1_0000_0000_0400;
            expPow[2] = 64'h00A2_0000_0000_0900;
            expPow[3] = 64'h00A3_0000_0000_0040;
            for (int k = 0; k < 8; k++) begin
                applyStimulus((k < 5) ? 4'b1111 : 4'b0000, 4'b1111);
                #1;
                if (k < 5) begin
                    checkOutput($sformatf("rr_grant_%0d", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
                end
                if (k >= 3) begin
                    checkOutput($sformatf("rr_resp_valid_%0d", k), 64'(resp_valid), 64'(4'b0001 << ((k - 3) % 4)));
                    checkOutput($sformatf("rr_resp_data_%0d", k), resp_data, expPow[(k - 3) % 4]);
                end
                nextCycle;
            end
        end

        // Backpressure: nothing popped, continuous requests
        applyReset();
        xfers = 0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b1111, 4'b0000);
            #1;
            if ((req_ready & req_valid) != '0) xfers++;
            nextCycle;
        end
        #1;
        checkOutput("bp_transfers", 64'(xfers), 64'd4);
        checkOutput("bp_blocked", 64'(req_ready), 64'h0);
        checkOutput("bp_fifo_full", 64'(dut.fifo_count), 64'd4);
`ifdef TMUL_ARB_STATS_EN
        checkOutput("stat_issued", 64'(stat_issued), 64'd4);
        checkOutput("stat_stall", 64'(stat_stall), 64'd4);
`endif
        applyStimulus(4'b1111, 4'b1111);
        #1;
        checkOutput("bp_head_owner", 64'(resp_valid), 64'h1);
        checkOutput("bp_pop_not_credited", 64'(req_ready), 64'h0);
        nextCycle;
        #1;
        checkOutput("bp_issue_restored", 64'(req_ready), 64'h1);
`ifdef TMUL_ARB_STATS_EN
        checkOutput("stat_stall_step", 64'(stat_stall), 64'd5);
`endif
        applyStimulus(4'b0000, 4'b1111);
        repeat (8) nextCycle;
        #1;
        checkOutput("bp_drained", 64'(resp_valid), 64'h0);

        // Simultaneous push and pop
        applyReset();
        setDir(1, mkDir(16'h00B1, 16'h0000, 16'h0180, 16'hFF00));
        setDir(3, mkDir(16'h00B3, 16'h0300, 16'hFF80, 16'h0040));
        applyStimulus(4'b0010, 4'b0000);
        nextCycle;
        applyStimulus(4'b1000, 4'b0000);
        #1;
        checkOutput("pp_grant3", 64'(req_ready), 64'h8);
        nextCycle;
        applyStimulus(4'b0000, 4'b0000);
        nextCycle;
        applyStimulus(4'b0000, 4'b0010);
        #1;
        checkOutput("pp_count_before", 64'(dut.fifo_count), 64'd1);
        checkOutput("pp_head1", resp_data, 64'h00B1_0000_0240_0100);
        nextCycle;
        applyStimulus(4'b0000, 4'b0000);
        #1;
        checkOutput("pp_count_after", 64'(dut.fifo_count), 64'd1);
        checkOutput("pp_owner3", 64'(resp_valid), 64'h8);
        checkOutput("pp_head3", resp_data, 64'h00B3_0900_0040_0010);
        applyStimulus(4'b0000, 4'b1000);
        nextCycle;
        #1;
        checkOutput("pp_empty", 64'(resp_valid), 64'h0);

        // Reset with two results queued and one in flight
        applyReset();
        setDir(0, mkDir(16'h00C0, 16'h0100, 16'h0100, 16'h0100));
        for (int k = 0; k < 4; k++) begin
            applyStimulus((k < 3) ? 4'b0001 : 4'b0000, 4'b0000);
            nextCycle;
        end
        #1;
        checkOutput("mid_queued", 64'(dut.fifo_count), 64'd2);
        checkOutput("mid_inflight", 64'(dut.pipe_valid), 64'h1);
        rst = 1'b1;
        #1;
        checkOutput("mid_mul_start", 64'(mul_start), 64'h0);
        checkOutput("mid_mul_dir", mul_dir, 64'h0);
        checkOutput("mid_resp_valid", 64'(resp_valid), 64'h0);
        checkOutput("mid_resp_data", resp_data, 64'h0);
        checkOutput("mid_req_ready", 64'(req_ready), 64'h0);
        nextCycle;
        rst = 1'b0;
        applyStimulus(4'b0000, 4'b0000);
        spurious = 0;
        for (int k = 0; k < 6; k++) begin
            nextCycle;
            if (resp_valid != '0) spurious++;
        end
        checkOutput("mid_no_late_resp", 64'(spurious), 64'd0);

        checkOutput("fifo_overflow", 64'(overflowEvents), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
